// File: rtl/cpu_clk_pkg.sv
// Shared definitions for the CPU step/run clock controller: controller
// states and the T-state (phase) encodings seen by the CPU datapath.
package cpu_clk_pkg;

    typedef enum logic [1:0] {
        ST_STOPPED  = 2'd0,
        ST_RUNNING  = 2'd1,
        ST_STEPPING = 2'd2,
        ST_HALTED   = 2'd3
    } step_state_t;

    localparam logic [1:0] T_FETCH  = 2'd0;
    localparam logic [1:0] T_DECODE = 2'd1;
    localparam logic [1:0] T_EXEC   = 2'd2;
    localparam logic [1:0] T_WB     = 2'd3;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser bringing an asynchronous level into the clk domain.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic meta_p0;

    // First flop may go metastable; second flop gives it a full cycle to settle.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            meta_p0 <= 1'b0;
            q       <= 1'b0;
        end else begin
            meta_p0 <= d;
            q       <= meta_p0;
        end
    end

endmodule

// File: rtl/cpu_step_ctrl.sv
// Run / single-step / halt controller for a four-T-state CPU. Generates a
// divided cpu_en pulse, tracks the current T-state and counts completed
// instructions. State changes out of RUNNING/STEPPING only happen on the
// cycle where the phase-3 (write-back) pulse is present.
module cpu_step_ctrl
    import cpu_clk_pkg::*;
#(
    parameter int DIV_W = 8,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             run_sw,
    input  logic             step_btn,
    input  logic             halt,
    input  logic [DIV_W-1:0] div,
    output logic             cpu_en,
    output logic [1:0]       phase,
    output logic             instr_done,
    output logic             running,
    output logic             halted,
    output logic [CNT_W-1:0] instr_cnt
);

    localparam logic [DIV_W-1:0] DIV_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Saturating instruction counter increment.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        if (&v) return v;
        return v + CNT_ONE;
    endfunction

    logic             run_sync;
    logic             step_sync;
    logic             step_prev;
    logic             step_edge;
    logic             boundary;

    step_state_t      state, state_nxt;
    logic [DIV_W-1:0] div_cnt, div_cnt_nxt, cnt_eval;
    logic [1:0]       phase_nxt;
    logic             cpu_en_nxt;
    logic             instr_done_nxt;

    sync_2ff u_sync_run (
        .clk (clk),
        .rst (rst),
        .d   (run_sw),
        .q   (run_sync)
    );

    sync_2ff u_sync_step (
        .clk (clk),
        .rst (rst),
        .d   (step_btn),
        .q   (step_sync)
    );

    assign step_edge = step_sync & ~step_prev;
    assign boundary  = cpu_en && (phase == T_WB);

    // Next state, divider compare and next pulse/phase values.
    always_comb begin
        state_nxt      = state;
        div_cnt_nxt    = '0;
        cnt_eval       = '0;
        cpu_en_nxt     = 1'b0;
        instr_done_nxt = 1'b0;
        // The phase shown during a pulse is held until that pulse completes.
        phase_nxt      = cpu_en ? phase + 2'd1 : phase;

        case (state)
            ST_STOPPED: begin
                if (run_sync)
                    state_nxt = ST_RUNNING;
                else if (step_edge)
                    state_nxt = ST_STEPPING;
            end
            ST_RUNNING: begin
                if (boundary) begin
                    if (halt)
                        state_nxt = ST_HALTED;
                    else if (!run_sync)
                        state_nxt = ST_STOPPED;
                end
            end
            ST_STEPPING: begin
                if (boundary)
                    state_nxt = halt ? ST_HALTED : ST_STOPPED;
            end
            ST_HALTED: begin
                if (!run_sync)
                    state_nxt = ST_STOPPED;
            end
            default: state_nxt = ST_STOPPED;
        endcase

        // On entry the count restarts from zero, so the first pulse lands
        // in the (div+1)th cycle of the new state.
        if (state_nxt == ST_RUNNING || state_nxt == ST_STEPPING) begin
            cnt_eval = (state_nxt != state) ? '0 : div_cnt;
            if (cnt_eval >= div) begin
                cpu_en_nxt     = 1'b1;
                div_cnt_nxt    = '0;
                instr_done_nxt = (phase_nxt == T_WB);
            end else begin
                div_cnt_nxt = cnt_eval + DIV_ONE;
            end
        end
    end

    // Controller state and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= ST_STOPPED;
            div_cnt    <= '0;
            cpu_en     <= 1'b0;
            instr_done <= 1'b0;
            phase      <= T_FETCH;
            running    <= 1'b0;
            halted     <= 1'b0;
            instr_cnt  <= '0;
            step_prev  <= 1'b0;
        end else begin
            state      <= state_nxt;
            div_cnt    <= div_cnt_nxt;
            cpu_en     <= cpu_en_nxt;
            instr_done <= instr_done_nxt;
            phase      <= phase_nxt;
            running    <= (state_nxt == ST_RUNNING);
            halted     <= (state_nxt == ST_HALTED);
            step_prev  <= step_sync;
            if (instr_done)
                instr_cnt <= sat_inc(instr_cnt);
        end
    end

endmodule

// File: tb/tb_cpu_step_ctrl.sv
// Directed bench for cpu_step_ctrl: a per-cycle vector table for reset and
// free-run, then hand-written sequences for stop, step, halt, reset and
// divider corner cases. A second instance with a 4-bit counter shares all
// inputs so counter saturation is reachable in a short run.
module tb_cpu_step_ctrl;

    logic        clk = 1'b0;
    logic        rst, run_sw, step_btn, halt;
    logic [7:0]  div;
    logic        cpu_en, instr_done, running, halted;
    logic [1:0]  phase;
    logic [15:0] instr_cnt;
    logic        s_en, s_done, s_run, s_hlt;
    logic [1:0]  s_ph;
    logic [3:0]  s_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    cpu_step_ctrl #(.DIV_W(8), .CNT_W(16)) dut (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .halt(halt),
        .div(div), .cpu_en(cpu_en), .phase(phase), .instr_done(instr_done),
        .running(running), .halted(halted), .instr_cnt(instr_cnt)
    );

    cpu_step_ctrl #(.DIV_W(8), .CNT_W(4)) dut_sat (
        .clk(clk), .rst(rst), .run_sw(run_sw), .step_btn(step_btn), .halt(halt),
        .div(div), .cpu_en(s_en), .phase(s_ph), .instr_done(s_done),
        .running(s_run), .halted(s_hlt), .instr_cnt(s_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct {
        logic       rst, run, step, hlt;
        logic [7:0] dv;
        logic       en;
        logic [1:0] ph;
        logic       done, run_f, hlt_f;
        logic [15:0] cnt;
    } vec_t;

    function automatic vec_t mk(input logic r, input logic rn, input logic st, input logic h,
                                input logic [7:0] d, input logic e, input logic [1:0] p,
                                input logic dn, input logic rf, input logic hf,
                                input logic [15:0] c);
        vec_t v;
        v.rst = r; v.run = rn; v.step = st; v.hlt = h; v.dv = d;
        v.en = e; v.ph = p; v.done = dn; v.run_f = rf; v.hlt_f = hf; v.cnt = c;
        return v;
    endfunction

    vec_t vecs[22];

    initial begin
        int n, pulses, cnt0, done_n;
        int pc[$];
        logic [1:0] pp[$];
        logic [3:0] pd[$];
        logic ok;

        rst = 1'b0; run_sw = 1'b0; step_btn = 1'b0; halt = 1'b0; div = 8'd0;

        //          rst run stp hlt div  en ph dn run hlt cnt
        vecs[0]  = mk(0, 0, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[1]  = mk(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[2]  = mk(1, 1, 0, 0, 0,   0, 0, 0, 0, 0, 0);
        vecs[3]  = mk(1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 0);
        vecs[4]  = mk(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 0);
        vecs[5]  = mk(1, 1, 0, 0, 0,   1, 2, 0, 1, 0, 0);
        vecs[6]  = mk(1, 1, 0, 0, 0,   1, 3, 1, 1, 0, 0);
        vecs[7]  = mk(1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 1);
        vecs[8]  = mk(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 1);
        vecs[9]  = mk(1, 1, 0, 0, 0,   1, 2, 0, 1, 0, 1);
        vecs[10] = mk(1, 1, 0, 0, 0,   1, 3, 1, 1, 0, 1);
        vecs[11] = mk(1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 2);
        vecs[12] = mk(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 2);
        vecs[13] = mk(1, 1, 0, 0, 0,   1, 2, 0, 1, 0, 2);
        vecs[14] = mk(1, 1, 0, 0, 0,   1, 3, 1, 1, 0, 2);
        vecs[15] = mk(1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 3);
        vecs[16] = mk(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 3);
        vecs[17] = mk(1, 1, 0, 0, 0,   1, 2, 0, 1, 0, 3);
        vecs[18] = mk(1, 1, 0, 0, 0,   1, 3, 1, 1, 0, 3);
        vecs[19] = mk(1, 1, 0, 0, 0,   1, 0, 0, 1, 0, 4);
        vecs[20] = mk(1, 1, 0, 0, 0,   1, 1, 0, 1, 0, 4);
        vecs[21] = mk(1, 1, 0, 0, 0,   1, 2, 0, 1, 0, 4);

        // Reset and free-run with div = 0, one vector per clock.
        for (int i = 0; i < 22; i++) begin
            rst = vecs[i].rst; run_sw = vecs[i].run; step_btn = vecs[i].step;
            halt = vecs[i].hlt; div = vecs[i].dv;
            @(negedge clk);
            chk($sformatf("vec%0d.cpu_en", i),     cpu_en,     vecs[i].en);
            chk($sformatf("vec%0d.phase", i),      phase,      vecs[i].ph);
            chk($sformatf("vec%0d.instr_done", i), instr_done, vecs[i].done);
            chk($sformatf("vec%0d.running", i),    running,    vecs[i].run_f);
            chk($sformatf("vec%0d.halted", i),     halted,     vecs[i].hlt_f);
            chk($sformatf("vec%0d.instr_cnt", i),  instr_cnt,  vecs[i].cnt);
            chk($sformatf("vec%0d.sat_cnt", i),    s_cnt,      vecs[i].cnt[3:0]);
            chk($sformatf("vec%0d.sat_en", i),     s_en,       vecs[i].en);
            chk($sformatf("vec%0d.sat_phase", i),  s_ph,       vecs[i].ph);
        end

        // run_sw drops at phase 1: instruction completes, then STOPPED.
        n = 0;
        while (!(cpu_en && phase == 2'd1) && n < 20) begin @(negedge clk); n++; end
        chk("stop.reach_phase1", cpu_en && phase == 2'd1, 1);
        run_sw = 1'b0;
        cnt0 = instr_cnt; pulses = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (cpu_en) pulses++;
        end while (running && n < 20);
        chk("stop.pulses_after_drop", pulses, 2);
        chk("stop.running", running, 0);
        chk("stop.phase", phase, 0);
        chk("stop.instr_cnt", instr_cnt, cnt0 + 1);
        ok = 1'b1;
        for (int i = 0; i < 4; i++) begin @(negedge clk); if (cpu_en) ok = 1'b0; end
        chk("stop.no_cpu_en", ok, 1);

        // Single step with div = 2; a second press mid-step is ignored.
        div = 8'd2; cnt0 = instr_cnt;
        step_btn = 1'b1;
        for (int c = 1; c <= 24; c++) begin
            if (c == 3) step_btn = 1'b0;
            if (c == 6) step_btn = 1'b1;
            if (c == 9) step_btn = 1'b0;
            @(negedge clk);
            if (cpu_en) begin pc.push_back(c); pp.push_back(phase); pd.push_back({3'd0, instr_done}); end
        end
        chk("step.pulse_count", pc.size(), 4);
        if (pc.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("step.pulse%0d_cycle", i), pc[i], 5 + 3 * i);
                chk($sformatf("step.pulse%0d_phase", i), pp[i], i);
                chk($sformatf("step.pulse%0d_done", i), pd[i], (i == 3) ? 1 : 0);
            end
        end
        chk("step.end_phase", phase, 0);
        chk("step.end_running", running, 0);
        chk("step.instr_cnt", instr_cnt, cnt0 + 1);

        // Run and step edges in the same cycle: run wins.
        div = 8'd0; run_sw = 1'b1; step_btn = 1'b1;
        @(negedge clk); @(negedge clk);
        chk("runwin.not_yet", running, 0);
        step_btn = 1'b0;
        @(negedge clk);
        chk("runwin.running", running, 1);
        chk("runwin.cpu_en", cpu_en, 1);

        // Halt at phase 1: finish the instruction, then HALTED until run_sw = 0.
        n = 0;
        while (!(cpu_en && phase == 2'd1) && n < 20) begin @(negedge clk); n++; end
        chk("halt.reach_phase1", cpu_en && phase == 2'd1, 1);
        halt = 1'b1; cnt0 = instr_cnt; pulses = 0; n = 0;
        do begin
            @(negedge clk); n++;
            if (cpu_en) pulses++;
        end while (!halted && n < 20);
        chk("halt.pulses_after_req", pulses, 2);
        chk("halt.halted", halted, 1);
        chk("halt.running", running, 0);
        chk("halt.phase", phase, 0);
        chk("halt.instr_cnt", instr_cnt, cnt0 + 1);
        halt = 1'b0;
        ok = 1'b1;
        for (int i = 0; i < 5; i++) begin @(negedge clk); if (cpu_en || !halted) ok = 1'b0; end
        chk("halt.held_idle", ok, 1);
        run_sw = 1'b0;
        @(negedge clk); @(negedge clk);
        chk("halt.still_halted", halted, 1);
        @(negedge clk);
        chk("halt.released", halted, 0);
        chk("halt.released_running", running, 0);
        chk("halt.sat_cnt_tracks", s_cnt, instr_cnt[3:0]);

        // Asynchronous reset during phase 2, then restart with run_sw held.
        run_sw = 1'b1; n = 0;
        while (!(cpu_en && phase == 2'd2) && n < 20) begin @(negedge clk); n++; end
        chk("rst.reach_phase2", cpu_en && phase == 2'd2, 1);
        #2 rst = 1'b0;
        #1;
        chk("rst.cpu_en", cpu_en, 0);
        chk("rst.phase", phase, 0);
        chk("rst.instr_done", instr_done, 0);
        chk("rst.running", running, 0);
        chk("rst.halted", halted, 0);
        chk("rst.instr_cnt", instr_cnt, 0);
        @(negedge clk); @(negedge clk);
        rst = 1'b1; n = 0;
        do begin @(negedge clk); n++; end while (!cpu_en && n < 20);
        chk("rst.first_pulse_latency", n, 3);
        chk("rst.first_pulse_phase", phase, 0);
        chk("rst.first_pulse_done", instr_done, 0);

        // Counter saturation on the 4-bit instance.
        n = 0;
        while (instr_cnt != 16'd17 && n < 200) begin @(negedge clk); n++; end
        chk("sat.main_cnt", instr_cnt, 17);
        chk("sat.sat_cnt", s_cnt, 15);
        for (int i = 0; i < 8; i++) @(negedge clk);
        chk("sat.sat_cnt_held", s_cnt, 15);

        // Lowering div mid-count takes effect on the next compare.
        div = 8'd5; n = 0;
        do begin @(negedge clk); n++; end while (!cpu_en && n < 20);
        chk("div.sync_pulse", cpu_en, 1);
        pc.delete();
        for (int c = 1; c <= 6; c++) begin
            if (c == 3) div = 8'd1;
            @(negedge clk);
            if (cpu_en) pc.push_back(c);
        end
        chk("div.pulse_count", pc.size(), 2);
        if (pc.size() == 2) begin
            chk("div.first_after_change", pc[0], 3);
            chk("div.second_after_change", pc[1], 5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/cpu_step_ctrl.md
CPU_STEP_CTRL -- requirements
Module: cpu_step_ctrl

Interface
REQ-001 SHALL have parameter DIV_W, default 8: width of rate divider input `div`.
REQ-002 SHALL have parameter CNT_W, default 16: width of completed-instruction counter.
REQ-003 SHALL have port clk  input  1: single clock; all state on rising edge.
REQ-004 SHALL have port rst  input  1: reset, asynchronous assert, active-low (0 = reset).
REQ-005 SHALL have port run_sw  input  1: asynchronous run switch, 1 = free-run.
REQ-006 SHALL have port step_btn  input  1: asynchronous single-step button, rising edge = one instruction.
REQ-007 SHALL have port halt  input  1: clk-domain halt request from CPU datapath.
REQ-008 SHALL have port div  input  DIV_W: cpu_en period minus one, sampled every cycle.
REQ-009 SHALL have port cpu_en  output  1: one-cycle CPU advance pulse.
REQ-010 SHALL have port phase  output  2: current T-state, 0 = FETCH, 1 = DECODE, 2 = EXEC, 3 = WB.
REQ-011 SHALL have port instr_done  output  1: pulse coincident with a cpu_en while phase = 3.
REQ-012 SHALL have ports running and halted  output  1 each: state flags.
REQ-013 SHALL have port instr_cnt  output  CNT_W: completed-instruction count.

Function
REQ-014 SHALL pass run_sw and step_btn through 2-FF synchronisers; step edge = sync output 1 with previous sync output 0.
REQ-015 SHALL implement FSM states STOPPED, RUNNING, STEPPING, HALTED.
REQ-016 STOPPED: SHALL go to RUNNING if synced run_sw = 1, else to STEPPING on a step edge; run SHALL win if both occur in the same cycle.
REQ-017 RUNNING/STEPPING: SHALL assert cpu_en when div_cnt >= div, then clear div_cnt; otherwise div_cnt increments. div_cnt SHALL clear on entry to either state.
REQ-018 SHALL make the first cpu_en after entry occur in the (div+1)th cycle of that state; div = 0 SHALL give a pulse every cycle.
REQ-019 SHALL advance phase by 1 modulo 4 on each cpu_en and never otherwise.
REQ-020 At an instruction boundary (cpu_en with phase = 3), RUNNING SHALL go to HALTED if halt = 1, else to STOPPED if synced run_sw = 0, else stay RUNNING.
REQ-021 At an instruction boundary, STEPPING SHALL go to HALTED if halt = 1, else to STOPPED.
REQ-022 Outside a boundary, halt and run_sw changes SHALL NOT alter state.
REQ-023 Step edges in RUNNING, STEPPING or HALTED SHALL be ignored, not queued.
REQ-024 HALTED SHALL go to STOPPED only when synced run_sw = 0; cpu_en SHALL stay 0 in HALTED and STOPPED.
REQ-025 SHALL increment instr_cnt on each instr_done, saturating at all-ones.
REQ-026 SHALL register all outputs; running = 1 only in RUNNING; halted = 1 only in HALTED.
REQ-027 SHALL change div between pulses only according to REQ-017: a smaller div takes effect on the next compare, with no lost or double pulse.

Reset
REQ-028 On rst = 0, SHALL immediately force: state STOPPED, cpu_en 0, instr_done 0, phase 0, div_cnt 0, instr_cnt 0, running 0, halted 0, synchroniser flops 0.
REQ-029 Reset mid-instruction SHALL abandon the instruction; phase SHALL restart at 0 with no instr_done.
REQ-030 With run_sw = 1 held through reset release, SHALL enter RUNNING after synchroniser latency, not in the release cycle.

Structure
REQ-031 SHALL take the FSM state enum and phase constants (T_FETCH, T_DECODE, T_EXEC, T_WB) from shared package cpu_clk_pkg.
REQ-032 SHALL use sub-module sync_2ff, instantiated twice (run_sw, step_btn).

Verification
REQ-033 Scenario: run_sw = 1, div = 0, halt = 0 for 20 cycles -> cpu_en every cycle; phase 0,1,2,3,0…; instr_done every 4th pulse; instr_cnt = 4 after 16 pulses.
REQ-034 Scenario: STOPPED, div = 2, step_btn pulse -> STEPPING on the 3rd edge after step_btn is first sampled; 4 cpu_en pulses 3 cycles apart; return to STOPPED with phase = 0 and instr_cnt += 1.
REQ-035 Scenario: RUNNING, halt = 1 at phase 1 -> phase completes 2,3; HALTED after the phase-3 pulse; no further cpu_en; run_sw = 0 then reaches STOPPED.
REQ-036 Scenario: run_sw drops at phase 1 -> instruction finishes, STOPPED at boundary; second step edge during STEPPING is ignored (exactly 4 pulses).
REQ-037 Scenario: instr_cnt preloaded via 65535 instructions with CNT_W = 16 -> stays 0xFFFF after further instr_done.
REQ-038 Scenario: rst = 0 asserted mid-phase 2 between clock edges -> all outputs reach reset values before the next edge; after release with run_sw = 1, first cpu_en has phase = 0.
